// File: rtl/exp5_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | exp5_pkg: state codes and defaults shared by the memory-game control   |
// | unit and the datapath debug display.                                   |
// | Rev 1.0                                                                |
// +----------------------------------------------------------------------+
package exp5_pkg;

  typedef enum logic [3:0] {
    ST_INICIAL       = 4'h0,
    ST_PREPARACAO    = 4'h1,
    ST_ESPERA_JOGADA = 4'h2,
    ST_REGISTRA      = 4'h4,
    ST_COMPARACAO    = 4'h5,
    ST_PROXIMO       = 4'h6,
    ST_FIM_ACERTOU   = 4'hA,
    ST_FIM_TIMEOUT   = 4'hD,
    ST_FIM_ERROU     = 4'hE
  } state_t;

  localparam int c_timeout_default = 3000;

endpackage
`default_nettype wire

// File: rtl/contador_m.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | contador_m: modulo-M counter with synchronous clear and saturation at  |
// | its terminal value M-1 (never wraps).                                  |
// | Rev 1.0                                                                |
// +----------------------------------------------------------------------+
module contador_m #(
  parameter int M = 3000,
  parameter int N = 12
) (
  input  logic clock,
  input  logic reset,
  input  logic zera,
  input  logic conta,
  output logic fim
);

  localparam logic [N-1:0] c_last = N'(M - 1);

  logic [N-1:0] r_count;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_count <= '0;
    end else if (zera) begin
      r_count <= '0;
    end else if (conta && (r_count != c_last)) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign fim = (r_count == c_last);

endmodule
`default_nettype wire

// File: rtl/exp5_unidade_controle.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | exp5_unidade_controle: Moore FSM sequencing one memory-game round of   |
// | up to 16 plays, with a per-play timeout.                               |
// | Rev 1.0                                                                |
// +----------------------------------------------------------------------+
module exp5_unidade_controle
  import exp5_pkg::*;
#(
  parameter int TIMEOUT = c_timeout_default,
  parameter int TW      = 12
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       iniciar,
  input  logic       jogada_feita,
  input  logic       igual,
  input  logic       fimC,
  output logic       zeraC,
  output logic       contaC,
  output logic       zeraR,
  output logic       registraR,
  output logic       pronto,
  output logic       acertou,
  output logic       errou,
  output logic       timeout,
  output logic [3:0] db_estado
);

  state_t r_state;
  state_t w_state_next;
  logic   w_espera;
  logic   w_tout_fim;

  assign w_espera = (r_state == ST_ESPERA_JOGADA);

  // Cleared outside the wait state, so every play gets a fresh window.
  contador_m #(
    .M (TIMEOUT),
    .N (TW)
  ) u_timeout_cnt (
    .clock (clock),
    .reset (reset),
    .zera  (!w_espera),
    .conta (w_espera),
    .fim   (w_tout_fim)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= ST_INICIAL;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = ST_INICIAL;
    case (r_state)
      ST_INICIAL:       w_state_next = iniciar ? ST_PREPARACAO : ST_INICIAL;
      ST_PREPARACAO:    w_state_next = ST_ESPERA_JOGADA;
      // A play arriving on the timeout cycle still counts.
      ST_ESPERA_JOGADA: begin
        if (jogada_feita)    w_state_next = ST_REGISTRA;
        else if (w_tout_fim) w_state_next = ST_FIM_TIMEOUT;
        else                 w_state_next = ST_ESPERA_JOGADA;
      end
      ST_REGISTRA:      w_state_next = ST_COMPARACAO;
      ST_COMPARACAO: begin
        if (!igual)    w_state_next = ST_FIM_ERROU;
        else if (fimC) w_state_next = ST_FIM_ACERTOU;
        else           w_state_next = ST_PROXIMO;
      end
      ST_PROXIMO:       w_state_next = ST_ESPERA_JOGADA;
      ST_FIM_ACERTOU:   w_state_next = iniciar ? ST_PREPARACAO : ST_FIM_ACERTOU;
      ST_FIM_TIMEOUT:   w_state_next = iniciar ? ST_PREPARACAO : ST_FIM_TIMEOUT;
      ST_FIM_ERROU:     w_state_next = iniciar ? ST_PREPARACAO : ST_FIM_ERROU;
      default:          w_state_next = ST_INICIAL;
    endcase
  end

  always_comb begin
    zeraC     = (r_state == ST_INICIAL) || (r_state == ST_PREPARACAO);
    zeraR     = zeraC;
    registraR = (r_state == ST_REGISTRA);
    contaC    = (r_state == ST_PROXIMO);
    acertou   = (r_state == ST_FIM_ACERTOU);
    errou     = (r_state == ST_FIM_ERROU);
    timeout   = (r_state == ST_FIM_TIMEOUT);
    pronto    = acertou || errou || timeout;
    db_estado = r_state;
  end

endmodule
`default_nettype wire

// File: tb/tb_exp5_unidade_controle.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_exp5_unidade_controle: directed self-checking bench, TIMEOUT = 8.   |
// | Rev 1.0                                                                |
// +----------------------------------------------------------------------+
module tb_exp5_unidade_controle;

  logic       clock = 1'b0;
  logic       reset;
  logic       iniciar, jogada_feita, igual, fimC;
  logic       zeraC, contaC, zeraR, registraR, pronto, acertou, errou, timeout;
  logic [3:0] db_estado;

  int n_compared   = 0;
  int n_mismatched = 0;
  int conta_pulses = 0;

  exp5_unidade_controle #(
    .TIMEOUT (8),
    .TW      (4)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .iniciar      (iniciar),
    .jogada_feita (jogada_feita),
    .igual        (igual),
    .fimC         (fimC),
    .zeraC        (zeraC),
    .contaC       (contaC),
    .zeraR        (zeraR),
    .registraR    (registraR),
    .pronto       (pronto),
    .acertou      (acertou),
    .errou        (errou),
    .timeout      (timeout),
    .db_estado    (db_estado)
  );

  always #5 clock = ~clock;

  always @(negedge clock) if (contaC === 1'b1) conta_pulses++;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Packed view of all 1-bit outputs: {zeraC,zeraR,registraR,contaC,pronto,acertou,errou,timeout}
  function automatic logic [7:0] flags();
    return {zeraC, zeraR, registraR, contaC, pronto, acertou, errou, timeout};
  endfunction

  task automatic check_state(input string name, input logic [3:0] exp_st, input logic [7:0] exp_fl);
    n_compared++;
    if (db_estado !== exp_st || flags() !== exp_fl) begin
      n_mismatched++;
      $display("FAIL %s: db_estado=%h flags=%b, expected db_estado=%h flags=%b",
               name, db_estado, flags(), exp_st, exp_fl);
    end
  endtask

  // Start from inicial or fim_*: lands in espera_jogada (entry edge just taken).
  task automatic start_round(input string name);
    iniciar = 1'b1;
    step();
    check_state({name, "_prep"}, 4'h1, 8'b1100_0000);
    iniciar = 1'b0;
    step();
    check_state({name, "_espera"}, 4'h2, 8'b0000_0000);
  endtask

  task automatic test_reset();
    reset = 1'b0; iniciar = 1'b0; jogada_feita = 1'b0; igual = 1'b0; fimC = 1'b0;
    #2;
    check_state("reset_async", 4'h0, 8'b1100_0000);
    step();
    reset = 1'b1;
    step();
    step();
    check_state("reset_idle_hold", 4'h0, 8'b1100_0000);
  endtask

  task automatic test_full_round();
    int p0;
    p0 = conta_pulses;
    start_round("full");
    for (int i = 0; i < 16; i++) begin
      jogada_feita = 1'b1; igual = 1'b1; fimC = (i == 15);
      step();
      check_state($sformatf("full_registra_%0d", i), 4'h4, 8'b0010_0000);
      jogada_feita = 1'b0;
      step();
      check_state($sformatf("full_compara_%0d", i), 4'h5, 8'b0000_0000);
      step();
      if (i < 15) begin
        check_state($sformatf("full_proximo_%0d", i), 4'h6, 8'b0001_0000);
        step();
        check_state($sformatf("full_espera_%0d", i), 4'h2, 8'b0000_0000);
      end
    end
    fimC = 1'b0;
    check_state("full_fim_acertou", 4'hA, 8'b0000_1100);
    step();
    check_state("full_fim_acertou_hold", 4'hA, 8'b0000_1100);
    n_compared++;
    if (conta_pulses - p0 !== 15) begin
      n_mismatched++;
      $display("FAIL full_contaC_pulses: got %0d, expected 15", conta_pulses - p0);
    end
  endtask

  task automatic test_errou();
    int p0;
    p0 = conta_pulses;
    start_round("err");
    for (int i = 0; i < 3; i++) begin
      jogada_feita = 1'b1; igual = (i < 2); fimC = 1'b0;
      step();
      jogada_feita = 1'b0;
      step();
      check_state($sformatf("err_compara_%0d", i), 4'h5, 8'b0000_0000);
      step();
      if (i < 2) step();
    end
    check_state("err_fim_errou", 4'hE, 8'b0000_1010);
    n_compared++;
    if (conta_pulses - p0 !== 2) begin
      n_mismatched++;
      $display("FAIL err_contaC_pulses: got %0d, expected 2", conta_pulses - p0);
    end
  endtask

  // iniciar from fim_errou restarts; ends in espera_jogada at the entry edge.
  task automatic test_restart_from_errou();
    igual = 1'b1;
    start_round("restart");
  endtask

  // Called right after the espera_jogada entry edge.
  task automatic test_timeout();
    for (int k = 1; k < 8; k++) begin
      step();
      check_state($sformatf("tout_wait_%0d", k), 4'h2, 8'b0000_0000);
    end
    step();
    check_state("tout_fim_timeout", 4'hD, 8'b0000_1001);
  endtask

  task automatic test_coincident();
    start_round("coinc");
    for (int k = 1; k < 8; k++) step();
    check_state("coinc_wait7", 4'h2, 8'b0000_0000);
    jogada_feita = 1'b1;
    step();
    check_state("coinc_registra", 4'h4, 8'b0010_0000);
    jogada_feita = 1'b0; igual = 1'b1; fimC = 1'b0;
    step();
    step();
    check_state("coinc_proximo", 4'h6, 8'b0001_0000);
    step();
    check_state("coinc_reentry", 4'h2, 8'b0000_0000);
    test_timeout();
  endtask

  task automatic test_reset_mid_comparacao();
    start_round("rstmid");
    jogada_feita = 1'b1; igual = 1'b1;
    step();
    jogada_feita = 1'b0;
    step();
    check_state("rstmid_comparacao", 4'h5, 8'b0000_0000);
    #2 reset = 1'b0;
    #1;
    check_state("rstmid_async", 4'h0, 8'b1100_0000);
    #2 reset = 1'b1;
    step();
    check_state("rstmid_after_release", 4'h0, 8'b1100_0000);
  endtask

  initial begin
    test_reset();
    test_full_round();
    test_errou();
    test_restart_from_errou();
    test_timeout();
    test_coincident();
    test_reset_mid_comparacao();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

endmodule
`default_nettype wire

// File: doc/exp5_unidade_controle.md
# exp5_unidade_controle

Moore control unit for the memory-game datapath (`exp5_fluxo_dados`). It sequences one round of up to 16 plays: it clears the address counter and play register, waits for a play, latches it, compares it against the stored ROM value, and advances the address. It finishes on success, error, or a play timeout. It drives the datapath's control inputs and consumes its `jogada_feita`, `igual` and `fimC` status outputs.

## Interface
- `TIMEOUT`, default 3000: number of cycles allowed in `espera_jogada` before a timeout; must be ≥2.
- `TW`, default 12: width of the timeout counter; must satisfy 2^TW ≥ TIMEOUT.
- `clock` input 1: single system clock, rising edge.
- `reset` input 1: asynchronous, active-low (0 = reset).
- `iniciar` input 1: start request, level-sampled.
- `jogada_feita` input 1: one-cycle play pulse from the datapath edge detector.
- `igual` input 1: comparator equality, ROM data == registered play.
- `fimC` input 1: address counter at 15.
- `zeraC` output 1: clear the address counter and edge detector.
- `contaC` output 1: increment the address counter.
- `zeraR` output 1: clear the play register.
- `registraR` output 1: load the play register.
- `pronto` output 1: round finished, in any `fim_*` state.
- `acertou` output 1: all 16 plays correct.
- `errou` output 1: wrong play.
- `timeout` output 1: no play within `TIMEOUT` cycles.
- `db_estado` output 4: current state code, for debug.

## Operation
- States and codes:
  - `inicial` = 0
  - `preparacao` = 1
  - `espera_jogada` = 2
  - `registra` = 4
  - `comparacao` = 5
  - `proximo` = 6
  - `fim_acertou` = A
  - `fim_timeout` = D
  - `fim_errou` = E
- Unused codes go to `inicial` on the next edge.
- Transitions:
  - `inicial`: to `preparacao` if `iniciar`, else stay.
  - `preparacao`: to `espera_jogada` unconditionally.
  - `espera_jogada`: to `registra` if `jogada_feita`; else to `fim_timeout` if the timeout count == `TIMEOUT`-1; else stay.
  - `registra`: to `comparacao`.
  - `comparacao`: to `fim_errou` if !`igual`; else to `fim_acertou` if `fimC`; else to `proximo`.
  - `proximo`: to `espera_jogada`.
  - `fim_*`: to `preparacao` if `iniciar`, else stay.
- Outputs are Moore, decoded from state only:
  - `zeraC` = `zeraR` = 1 in `inicial` and `preparacao`.
  - `registraR` = 1 in `registra` only.
  - `contaC` = 1 in `proximo` only.
  - `pronto` = 1 in all three `fim_*` states.
  - `acertou`, `errou` and `timeout` are each 1 only in their own `fim_*` state, and are mutually exclusive.
- Timeout counter:
  - TW bits wide.
  - Cleared in every state other than `espera_jogada`.
  - Increments by 1 per cycle in `espera_jogada`.
  - Saturates at `TIMEOUT`-1; never wraps.
  - It restarts at 0 on each entry to `espera_jogada`, so each play gets a full `TIMEOUT` window.
- `jogada_feita` and the timeout condition in the same cycle: the play wins, go to `registra`.
- `igual` is sampled only in `comparacao`. `fimC` is sampled only in `comparacao` with `igual`=1.

## Timing
- Reset asserted, at any time and in any state: state = `inicial` immediately, with no clock needed.
  - Outputs then read `zeraC`=1, `zeraR`=1, all other outputs 0, `db_estado`=0.
  - Deassertion is synchronised externally; the FSM begins moving on the first rising edge after `reset`=1.
- From `iniciar` sampled high in `inicial` to `espera_jogada` takes 2 edges.
- Per play, from the `jogada_feita` edge:
  - `registra` for 1 cycle; the play register loads at the end of it.
  - `comparacao` for 1 cycle; `igual` is valid because the register Q is stable and the synchronous ROM output settled earlier.
  - `proximo` for 1 cycle.
  - Back in `espera_jogada` 3 edges after the pulse.
- The ROM output for the new address is valid 1 cycle after `contaC`. This is before any play can be compared, since at least `registra` intervenes.
- The last play (address 15, `fimC`=1, `igual`=1) reaches `fim_acertou` with no `contaC`; the counter stays at 15.
- Timeout: with no play, `fim_timeout` is entered exactly `TIMEOUT` cycles after entering `espera_jogada`.
- `iniciar` held high through `fim_*` restarts immediately; `iniciar` is ignored in all other non-`inicial` states.

## Structure
- Shared package `exp5_pkg` holds:
  - the 4-bit state code constants listed above;
  - the default `TIMEOUT` value.
- The datapath top level also uses these constants for the `db_estado` display decode.
- The timeout counter is one natural sub-module, `contador_m`: generic modulo-M with `zera`, `conta`, `fim` and saturate-at-`fim` behaviour, and the same asynchronous active-low `reset`.
- The FSM consists of a state register, next-state logic and output decode, all in `exp5_unidade_controle`.

## Test plan
- Reset mid-`comparacao` (assert `reset`=0 between edges) → `db_estado`=0, `zeraC`=1, `zeraR`=1 before the next edge; all flags 0.
- `iniciar` pulse, then 16 plays each with `igual`=1 and `fimC`=1 on the 16th → exactly 15 `contaC` pulses; `db_estado` ends at A; `acertou`=1, `pronto`=1.
- Third play compared with `igual`=0 → `db_estado`=E, `errou`=1, `pronto`=1; only 2 `contaC` pulses were issued.
- `TIMEOUT`=8, no play after start → `fim_timeout` on the 8th edge after entering `espera_jogada`; `timeout`=1.
- `TIMEOUT`=8, `jogada_feita` coincident with count 7 → `registra` is entered, not `fim_timeout`; the next wait restarts the count at 0.
- In `fim_errou`, `iniciar`=1 → `preparacao` (`zeraC`=`zeraR`=1, `errou`=0), then `espera_jogada` on the following edge.
